seq_alu: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_shift_unit.sv | 30 +++
 rtl/seq_alu.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for seq_alu: opcodes, shift modes and FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_FWD   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational barrel shifter: SLL / SRL / SRA / ROR of data by amount (0..WIDTH-1).
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   amount,
    output logic [WIDTH-1:0] out
);

    logic [2*WIDTH-1:0] rot_wide;

    // Rotating the doubled word keeps ROR free of a WIDTH-amount shift when amount is 0.
    assign rot_wide = {data, data} >> amount;

    always_comb begin
        out = data;
        case (mode)
            SH_SLL: out = data << amount;
            SH_SRL: out = data >> amount;
            SH_SRA: out = WIDTH'($signed(data) >>> amount);
            SH_ROR: out = rot_wide[WIDTH-1:0];
            default: out = data;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with START/BUSY/DONE handshake; iterative MUL when SEQ_ALU_MUL_EN is defined.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] single_res;

    alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .data   (DATA1),
        .mode   (DATA2[WIDTH-1 -: 2]),
        .amount (DATA2[SHW-1:0]),
        .out    (shift_out)
    );

    // Single-cycle result; MUL and reserved opcodes fall to zero here.
    always_comb begin
        single_res = '0;
        case (SELECT)
            ALU_FWD:   single_res = DATA2;
            ALU_ADD:   single_res = DATA1 + DATA2;
            ALU_AND:   single_res = DATA1 & DATA2;
            ALU_OR:    single_res = DATA1 | DATA2;
            ALU_SHIFT: single_res = shift_out;
            default:   single_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    state_e           state;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_acc;
    logic [SHW-1:0]   mul_cnt;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = mul_b[0] ? mul_acc + mul_a : mul_acc;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            RESULT  <= '0;
            ZERO    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (SELECT == ALU_MUL) begin
                            mul_a   <= DATA1;
                            mul_b   <= DATA2;
                            mul_acc <= '0;
                            mul_cnt <= '0;
                            BUSY    <= 1'b1;
                            state   <= ST_MUL;
                        end else begin
                            RESULT <= single_res;
                            ZERO   <= (single_res == '0);
                            DONE   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    mul_acc <= acc_next;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + SHW'(1);
                    // Last step folds its partial product straight into RESULT.
                    if (mul_cnt == SHW'(WIDTH - 1)) begin
                        RESULT <= acc_next;
                        ZERO   <= (acc_next == '0);
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign BUSY = 1'b0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RESULT <= '0;
            ZERO   <= 1'b1;
            DONE   <= 1'b0;
        end else begin
            DONE <= START;
            if (START) begin
                RESULT <= single_res;
                ZERO   <= (single_res == '0);
            end
        end
    end
`endif

endmodule
